// File: rtl/bp_update_arbiter_if.sv
// Purpose: bundles the two branch-resolve request channels and the predictor update port.
// Latency: n/a (wires only).
// Backpressure: readys flow from the arbiter back to the requesters.
interface bp_update_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_pc;
  logic        req0_taken;
  logic [31:0] req0_target;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_pc;
  logic        req1_taken;
  logic [31:0] req1_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  // Requester / consumer side
  modport master (
    output req0_valid, req0_pc, req0_taken, req0_target,
    output req1_valid, req1_pc, req1_taken, req1_target,
    input  req0_ready, req1_ready,
    input  upd_en, upd_pc, upd_taken, upd_target
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_pc, req0_taken, req0_target,
    input  req1_valid, req1_pc, req1_taken, req1_target,
    output req0_ready, req1_ready,
    output upd_en, upd_pc, upd_taken, upd_target
  );
endinterface

// File: rtl/bp_update_arbiter.sv
// Purpose: round-robin arbitration of two branch-resolve updates into an in-order queue feeding the predictor update port.
// Latency: 1 cycle from accept edge to upd_en when the queue is empty and hold is low.
// Backpressure: readys drop when the queue is full or flush is high; hold/flush pause issue.
module bp_update_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STAT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  bp_update_arbiter_if.slave            bus,
  input  logic                          hold,
  input  logic                          flush,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [STAT_W-1:0]             stat_issued,
  output logic [STAT_W-1:0]             stat_contention
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  entry_t             q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               rr_pri;   // 0: port 0 wins a tie, 1: port 1 wins

  logic               both_vld;
  logic               has_room;
  logic               grant0;
  logic               grant1;
  logic               push;
  logic               pop;
  logic               pri_acc;
  entry_t             push_ent;
  entry_t             head;

  // Grant selection, accept handshake and head-of-queue issue decode.
  always_comb begin
    both_vld = bus.req0_valid && bus.req1_valid;
    // rst_n gate keeps readys low while held in reset, matching the other outputs.
    has_room = rst_n && !flush && (count < CNT_W'(FIFO_DEPTH));
    grant0   = bus.req0_valid && (!bus.req1_valid || !rr_pri);
    grant1   = bus.req1_valid && (!bus.req0_valid ||  rr_pri);
    bus.req0_ready = grant0 && has_room;
    bus.req1_ready = grant1 && has_room;
    push     = (grant0 || grant1) && has_room;
    pri_acc  = has_room && (rr_pri ? grant1 : grant0);

    push_ent.pc     = grant1 ? bus.req1_pc     : bus.req0_pc;
    push_ent.taken  = grant1 ? bus.req1_taken  : bus.req0_taken;
    push_ent.target = grant1 ? bus.req1_target : bus.req0_target;

    // Pop only from a non-empty queue; a full queue never pops-through a new push.
    pop  = (count != '0) && !hold && !flush;
    head = q[rd_ptr];
    bus.upd_en     = pop;
    bus.upd_pc     = pop ? head.pc     : '0;
    bus.upd_taken  = pop ? head.taken  : 1'b0;
    bus.upd_target = pop ? head.target : '0;
  end

  assign fifo_count = count;

  // Queue pointers and occupancy; flush empties the queue at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents are only observed once counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= push_ent;
  end

  // Round-robin priority and saturating statistics; both survive flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_pri          <= 1'b0;
      stat_issued     <= '0;
      stat_contention <= '0;
    end else begin
      if (pri_acc) rr_pri <= ~rr_pri;
      if (pop && (stat_issued != '1))
        stat_issued <= stat_issued + STAT_W'(1);
      if (both_vld && !flush && (stat_contention != '1))
        stat_contention <= stat_contention + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Purpose: directed stimulus for bp_update_arbiter with a queue-based reference model checked every cycle.
// Latency: checks sample 3 time units after the rising edge and on the falling edge.
// Backpressure: requesters hold valid until their ready is observed.
module tb_bp_update_arbiter;
  localparam int DEPTH = 4;
  localparam int SW    = 4;
  localparam int SMAX  = 15;

  logic          clk;
  logic          rst_n;
  logic          hold;
  logic          flush;
  logic [2:0]    fifo_count;
  logic [SW-1:0] stat_issued;
  logic [SW-1:0] stat_contention;

  bp_update_arbiter_if bus ();

  bp_update_arbiter #(.FIFO_DEPTH(DEPTH), .STAT_W(SW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .hold            (hold),
    .flush           (flush),
    .fifo_count      (fifo_count),
    .stat_issued     (stat_issued),
    .stat_contention (stat_contention)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tg;
  } ent_t;

  ent_t mq[$];
  int   m_rr  = 0;
  int   m_iss = 0;
  int   m_con = 0;

  // Predict outputs from the model, compare, then advance the model for the coming edge.
  always @(negedge clk) begin
    logic room, r0, r1, en, both;
    int   g;
    ent_t hd;
    if (!rst_n) begin
      mq.delete();
      m_rr = 0; m_iss = 0; m_con = 0;
    end
    both = bus.req0_valid && bus.req1_valid;
    room = rst_n && !flush && (mq.size() < DEPTH);
    if (both)                 g = m_rr;
    else if (bus.req0_valid)  g = 0;
    else if (bus.req1_valid)  g = 1;
    else                      g = -1;
    r0 = room && (g == 0);
    r1 = room && (g == 1);
    en = rst_n && (mq.size() > 0) && !hold && !flush;
    hd = en ? mq[0] : '{32'h0, 1'b0, 32'h0};

    chk("m_req0_ready", bus.req0_ready, r0);
    chk("m_req1_ready", bus.req1_ready, r1);
    chk("m_upd_en", bus.upd_en, en);
    chk("m_upd_pc", bus.upd_pc, hd.pc);
    chk("m_upd_taken", bus.upd_taken, hd.tk);
    chk("m_upd_target", bus.upd_target, hd.tg);
    chk("m_fifo_count", fifo_count, mq.size());
    chk("m_stat_issued", stat_issued, m_iss);
    chk("m_stat_contention", stat_contention, m_con);

    if (rst_n && flush) begin
      mq.delete();
    end else if (rst_n) begin
      if (en) begin
        void'(mq.pop_front());
        m_iss = (m_iss + 1 > SMAX) ? SMAX : m_iss + 1;
      end
      if (r0) mq.push_back('{bus.req0_pc, bus.req0_taken, bus.req0_target});
      if (r1) mq.push_back('{bus.req1_pc, bus.req1_taken, bus.req1_target});
      if ((r0 || r1) && (g == m_rr)) m_rr = 1 - m_rr;
      if (both) m_con = (m_con + 1 > SMAX) ? SMAX : m_con + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set0(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    bus.req0_valid = v; bus.req0_pc = pc; bus.req0_taken = tk; bus.req0_target = tg;
  endtask

  task automatic set1(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    bus.req1_valid = v; bus.req1_pc = pc; bus.req1_taken = tk; bus.req1_target = tg;
  endtask

  task automatic do_reset();
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    hold  = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    set0(1, 32'h99, 1, 32'h98);
    set1(0, 0, 0, 0);
    tick();
    settle();
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_upd_en", bus.upd_en, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_issued", stat_issued, 0);

    // T1 single update
    do_reset();
    set0(1, 32'h100, 1, 32'h200);
    settle();
    chk("t1_ready", bus.req0_ready, 1);
    chk("t1_en_before", bus.upd_en, 0);
    tick();
    set0(0, 0, 0, 0);
    settle();
    chk("t1_en", bus.upd_en, 1);
    chk("t1_pc", bus.upd_pc, 32'h100);
    chk("t1_taken", bus.upd_taken, 1);
    chk("t1_target", bus.upd_target, 32'h200);
    chk("t1_count1", fifo_count, 1);
    tick();
    settle();
    chk("t1_en_after", bus.upd_en, 0);
    chk("t1_count0", fifo_count, 0);
    chk("t1_issued", stat_issued, 1);

    // T2 contention
    do_reset();
    set0(1, 32'h10, 0, 32'h11);
    set1(1, 32'h20, 1, 32'h21);
    settle();
    chk("t2_r0_c0", bus.req0_ready, 1);
    chk("t2_r1_c0", bus.req1_ready, 0);
    tick();
    set0(0, 0, 0, 0);
    settle();
    chk("t2_r1_c1", bus.req1_ready, 1);
    chk("t2_pc0", bus.upd_pc, 32'h10);
    tick();
    set1(0, 0, 0, 0);
    settle();
    chk("t2_pc1", bus.upd_pc, 32'h20);
    chk("t2_contention", stat_contention, 1);
    tick();
    settle();
    chk("t2_issued", stat_issued, 2);

    // T3 full queue, no pop-through
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set0(1, 32'h40 + 32'(4 * i), i[0], 32'h1000 + 32'(i));
      settle();
      chk("t3_push_ready", bus.req0_ready, 1);
      tick();
    end
    set0(1, 32'h50, 1, 32'h1004);
    settle();
    chk("t3_count4", fifo_count, 4);
    chk("t3_full_ready", bus.req0_ready, 0);
    tick();
    hold = 1'b0;
    settle();
    chk("t3_nopopthru", bus.req0_ready, 0);
    chk("t3_pc40", bus.upd_pc, 32'h40);
    tick();
    settle();
    chk("t3_ready_room", bus.req0_ready, 1);
    chk("t3_pc44", bus.upd_pc, 32'h44);
    tick();
    set0(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t3_drain_en", bus.upd_en, 1);
      chk("t3_drain_pc", bus.upd_pc, 32'h48 + 32'(4 * i));
      tick();
    end
    settle();
    chk("t3_empty", fifo_count, 0);
    chk("t3_issued", stat_issued, 5);

    // T4 flush keeps rr and stats
    do_reset();
    hold = 1'b1;
    set0(1, 32'h60, 0, 32'h0); tick(); set0(0, 0, 0, 0);
    set1(1, 32'h64, 0, 32'h0); tick(); set1(0, 0, 0, 0);
    set0(1, 32'h68, 0, 32'h0); tick();
    hold  = 1'b0;
    flush = 1'b1;
    set0(1, 32'h70, 0, 32'h7);
    set1(1, 32'h74, 1, 32'h8);
    settle();
    chk("t4_flush_r0", bus.req0_ready, 0);
    chk("t4_flush_r1", bus.req1_ready, 0);
    chk("t4_flush_en", bus.upd_en, 0);
    chk("t4_count3", fifo_count, 3);
    tick();
    flush = 1'b0;
    settle();
    chk("t4_count0", fifo_count, 0);
    chk("t4_no_en", bus.upd_en, 0);
    chk("t4_rr_r1", bus.req1_ready, 1);
    chk("t4_rr_r0", bus.req0_ready, 0);
    chk("t4_cont_kept", stat_contention, 0);
    tick();
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    settle();
    chk("t4_pc74", bus.upd_pc, 32'h74);
    chk("t4_contention", stat_contention, 1);

    // T5 async reset mid-operation
    do_reset();
    set0(1, 32'hA0, 0, 32'h0);
    set1(1, 32'hB0, 0, 32'h0);
    settle();
    chk("t5_r0", bus.req0_ready, 1);
    tick();
    set0(0, 0, 0, 0);
    settle();
    chk("t5_pcA0", bus.upd_pc, 32'hA0);
    tick();
    hold = 1'b1;
    set1(0, 0, 0, 0);
    set0(1, 32'hC0, 0, 32'h0);
    tick();
    set0(0, 0, 0, 0);
    settle();
    chk("t5_count2", fifo_count, 2);
    chk("t5_issued1", stat_issued, 1);
    chk("t5_cont1", stat_contention, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_en", bus.upd_en, 0);
    chk("t5_async_count", fifo_count, 0);
    chk("t5_async_issued", stat_issued, 0);
    chk("t5_async_cont", stat_contention, 0);
    hold = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("t5_post_en", bus.upd_en, 0);
    tick();
    settle();
    chk("t5_post_count", fifo_count, 0);

    // T6 pointer wrap and stat saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        set1(0, 0, 0, 0);
        set0(1, 32'h200 + 32'(4 * i), 1, 32'h300 + 32'(i));
      end else begin
        set0(0, 0, 0, 0);
        set1(1, 32'h200 + 32'(4 * i), 0, 32'h300 + 32'(i));
      end
      settle();
      chk("t6_ready", (i % 2 == 0) ? bus.req0_ready : bus.req1_ready, 1);
      if (i > 0) chk("t6_order", bus.upd_pc, 32'h200 + 32'(4 * (i - 1)));
      tick();
    end
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    settle();
    chk("t6_last", bus.upd_pc, 32'h200 + 32'(4 * 19));
    tick();
    settle();
    chk("t6_empty", fifo_count, 0);
    chk("t6_sat", stat_issued, 15);
    chk("t6_model_sat", m_iss, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
